pipelined_accum_adder: RTL and testbench

//   Parametrised, registered successor to the single-cycle 8-bit example adder: valid/ready

---
 rtl/pipelined_accum_adder.sv | 150 +++++++++++++++
 tb/tb_pipelined_accum_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_accum_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_accum_adder                                        |
// | Description : Registered add/sub/accumulate/load unit with valid/ready     |
// |               intake, optional saturation, signed or unsigned overflow,    |
// |               sticky overflow flag and accepted-operation counter.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipelined_accum_adder #(
  parameter int               WIDTH    = 8,
  parameter int               SIGNED   = 0,
  parameter logic [WIDTH-1:0] ACC_INIT = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  input  logic             sat_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc_out,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0]       c_mode_add  = 2'b00;
  localparam logic [1:0]       c_mode_sub  = 2'b01;
  localparam logic [1:0]       c_mode_acc  = 2'b10;
  localparam logic [1:0]       c_mode_load = 2'b11;
  localparam logic [WIDTH-1:0] c_sat_pos   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_sat_neg   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_all_ones  = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_accept;
  logic             w_clr;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH:0]   w_sum_ab;
  logic [WIDTH:0]   w_sum_acc;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_raw;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final;

  // Intake handshake; held off during reset so nothing is taken while rst_n is low.
  always_comb begin
    in_ready = rst_n & ena & (~out_valid | out_ready);
    w_accept = in_valid & in_ready;
    w_clr    = ena & acc_clr;
    // A clear in the same cycle as an accept is applied before the operation.
    w_acc_base = w_clr ? ACC_INIT : acc_out;
  end

  // Raw arithmetic, overflow detection and optional clamping.
  always_comb begin
    w_sum_ab  = {1'b0, op_a} + {1'b0, op_b};
    w_sum_acc = {1'b0, w_acc_base} + {1'b0, op_a};
    w_diff    = op_a - op_b;
    w_raw     = op_a;
    w_ovf     = 1'b0;
    case (mode)
      c_mode_add: begin
        w_raw = w_sum_ab[WIDTH-1:0];
        if (SIGNED != 0)
          w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_raw[WIDTH-1] != op_a[WIDTH-1]);
        else
          w_ovf = w_sum_ab[WIDTH];
      end
      c_mode_sub: begin
        w_raw = w_diff;
        if (SIGNED != 0)
          w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_raw[WIDTH-1] != op_a[WIDTH-1]);
        else
          w_ovf = (op_a < op_b);
      end
      c_mode_acc: begin
        w_raw = w_sum_acc[WIDTH-1:0];
        if (SIGNED != 0)
          w_ovf = (w_acc_base[WIDTH-1] == op_a[WIDTH-1]) && (w_raw[WIDTH-1] != op_a[WIDTH-1]);
        else
          w_ovf = w_sum_acc[WIDTH];
      end
      c_mode_load: begin
        w_raw = op_a;
        w_ovf = 1'b0;
      end
      default: begin
        w_raw = op_a;
        w_ovf = 1'b0;
      end
    endcase

    // Signed overflow direction follows op_a's sign: every overflowing case has
    // op_a sharing the sign of the true (unrepresentable) result.
    w_final = w_raw;
    if (sat_en && w_ovf) begin
      if (SIGNED != 0)
        w_final = op_a[WIDTH-1] ? c_sat_neg : c_sat_pos;
      else
        w_final = (mode == c_mode_sub) ? '0 : c_all_ones;
    end
  end

  // Output register: load on accept, drop valid when consumed with no new op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      result    <= w_final;
      ovf       <= w_ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator, sticky overflow and op counter, with clear ordered before the op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out    <= ACC_INIT;
      ovf_sticky <= 1'b0;
      op_count   <= '0;
    end else if (w_accept) begin
      if (mode == c_mode_acc)
        acc_out <= w_final;
      else if (mode == c_mode_load)
        acc_out <= op_a;
      else
        acc_out <= w_acc_base;
      ovf_sticky <= (w_clr ? 1'b0 : ovf_sticky) | w_ovf;
      op_count   <= (w_clr ? '0 : op_count) + c_cnt_one;
    end else if (w_clr) begin
      acc_out    <= ACC_INIT;
      ovf_sticky <= 1'b0;
      op_count   <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_accum_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipelined_accum_adder                                     |
// | Description : Directed self-checking bench for pipelined_accum_adder with  |
// |               an unsigned and a signed instance sharing one stimulus.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipelined_accum_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] mode;
  logic       sat_en;
  logic       acc_clr;
  logic       out_ready;

  logic        u_in_ready, u_out_valid, u_ovf, u_ovf_sticky;
  logic [7:0]  u_result, u_acc;
  logic [15:0] u_count;
  logic        s_in_ready, s_out_valid, s_ovf, s_ovf_sticky;
  logic [7:0]  s_result, s_acc;
  logic [15:0] s_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_accum_adder #(.WIDTH(8), .SIGNED(0), .ACC_INIT(8'h00), .CNT_W(16)) u_uns (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(u_in_ready),
    .op_a(op_a), .op_b(op_b), .mode(mode), .sat_en(sat_en), .acc_clr(acc_clr),
    .out_valid(u_out_valid), .out_ready(out_ready), .result(u_result), .ovf(u_ovf),
    .ovf_sticky(u_ovf_sticky), .acc_out(u_acc), .op_count(u_count)
  );

  pipelined_accum_adder #(.WIDTH(8), .SIGNED(1), .ACC_INIT(8'h00), .CNT_W(16)) u_sgn (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(s_in_ready),
    .op_a(op_a), .op_b(op_b), .mode(mode), .sat_en(sat_en), .acc_clr(acc_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result), .ovf(s_ovf),
    .ovf_sticky(s_ovf_sticky), .acc_out(s_acc), .op_count(s_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic s);
    in_valid = 1'b1;
    mode     = m;
    op_a     = a;
    op_b     = b;
    sat_en   = s;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
    mode = 2'b00; sat_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_in_ready", u_in_ready, 0);
    tick();
    check("rst_out_valid", u_out_valid, 0);
    check("rst_result", u_result, 0);
    check("rst_acc", u_acc, 0);
    check("rst_count", u_count, 0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", u_in_ready, 1);

    // Unsigned ADD overflow, wrap then saturate
    drive(2'b00, 8'd200, 8'd100, 1'b0);
    tick();
    check("uadd_wrap_res", u_result, 8'h2C);
    check("uadd_wrap_ovf", u_ovf, 1);
    check("uadd_wrap_valid", u_out_valid, 1);
    drive(2'b00, 8'd200, 8'd100, 1'b1);
    tick();
    check("uadd_sat_res", u_result, 8'hFF);
    check("uadd_sat_ovf", u_ovf, 1);

    // Signed SUB -100-100 saturate, then wrap
    drive(2'b01, 8'h9C, 8'h64, 1'b1);
    tick();
    check("ssub_sat_res", s_result, 8'h80);
    check("ssub_sat_ovf", s_ovf, 1);
    drive(2'b01, 8'h9C, 8'h64, 1'b0);
    tick();
    check("ssub_wrap_res", s_result, 8'h38);
    check("ssub_wrap_ovf", s_ovf, 1);

    // 0x50+0x50: signed positive overflow, unsigned fine
    drive(2'b00, 8'h50, 8'h50, 1'b1);
    tick();
    check("sadd_pos_sat", s_result, 8'h7F);
    check("uadd_noovf_res", u_result, 8'hA0);
    check("uadd_noovf_ovf", u_ovf, 0);

    // 5-9: unsigned borrow clamps to 0, signed gives -4
    drive(2'b01, 8'd5, 8'd9, 1'b1);
    tick();
    check("usub_sat_res", u_result, 8'h00);
    check("usub_sat_ovf", u_ovf, 1);
    check("ssub_neg_res", s_result, 8'hFC);
    check("ssub_neg_ovf", s_ovf, 0);
    check("u_sticky_set", u_ovf_sticky, 1);

    // Clear with LOAD in the same cycle, then back-to-back accumulate
    acc_clr = 1'b1;
    drive(2'b11, 8'd10, 8'd0, 1'b0);
    tick();
    acc_clr = 1'b0;
    check("load_res", u_result, 8'd10);
    check("clr_load_count", u_count, 1);
    drive(2'b10, 8'd5, 8'd0, 1'b0);
    tick();
    check("acc1_res", u_result, 8'd15);
    drive(2'b10, 8'd7, 8'd0, 1'b0);
    tick();
    check("acc2_res", u_result, 8'd22);
    check("acc2_valid", u_out_valid, 1);
    check("acc_out_22", u_acc, 8'd22);
    check("count_3", u_count, 3);
    check("sticky_clr", u_ovf_sticky, 0);

    // Backpressure: first op held, second waits until consume
    in_valid = 1'b0;
    tick();
    check("drain_valid", u_out_valid, 0);
    out_ready = 1'b0;
    drive(2'b11, 8'h33, 8'h00, 1'b0);
    tick();
    check("bp_first_res", u_result, 8'h33);
    drive(2'b11, 8'h44, 8'h00, 1'b0);
    #1;
    check("bp_in_ready", u_in_ready, 0);
    tick();
    check("bp_hold_res", u_result, 8'h33);
    check("bp_hold_acc", u_acc, 8'h33);
    check("bp_hold_count", u_count, 4);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", u_in_ready, 1);
    tick();
    check("bp_second_res", u_result, 8'h44);
    check("bp_second_valid", u_out_valid, 1);
    check("bp_second_count", u_count, 5);
    in_valid = 1'b0;
    tick();
    check("bp_drain_valid", u_out_valid, 0);

    // ena low: no accept, no clear
    ena = 1'b0;
    acc_clr = 1'b1;
    drive(2'b11, 8'h77, 8'h00, 1'b0);
    #1;
    check("dis_in_ready", u_in_ready, 0);
    tick();
    check("dis_valid", u_out_valid, 0);
    check("dis_acc", u_acc, 8'h44);
    check("dis_count", u_count, 5);
    ena = 1'b1;
    acc_clr = 1'b0;

    // Unsigned accumulate saturation
    drive(2'b11, 8'hF0, 8'h00, 1'b0);
    tick();
    drive(2'b10, 8'h20, 8'h00, 1'b1);
    tick();
    check("uacc_sat_res", u_result, 8'hFF);
    check("uacc_sat_acc", u_acc, 8'hFF);
    check("uacc_sat_count", u_count, 7);

    // Async reset mid-cycle with an unconsumed result
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", u_out_valid, 0);
    check("arst_acc", u_acc, 0);
    check("arst_count", u_count, 0);
    check("arst_sticky", u_ovf_sticky, 0);
    check("arst_in_ready", u_in_ready, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
